// File: rtl/rename_ctrl_if.sv
// Rename-side handshake bundle between the rename stage and the rename controller:
// rename request/response, writeback, commit and flush.
interface rename_ctrl_if #(
  parameter int unsigned NUM_LRS    = 10,
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned LW = $clog2(NUM_LRS);

  logic                  req_valid;
  logic [LW-1:0]         req_lr;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] rsp_pr;
  logic [ADDR_WIDTH-1:0] rsp_old_pr;
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_pr;
  logic                  commit_valid;
  logic [LW-1:0]         commit_lr;
  logic [ADDR_WIDTH-1:0] commit_pr;
  logic                  flush;

  modport master (
    output req_valid, req_lr, wb_valid, wb_pr, commit_valid, commit_lr, commit_pr, flush,
    input  req_ready, rsp_pr, rsp_old_pr
  );

  modport slave (
    input  req_valid, req_lr, wb_valid, wb_pr, commit_valid, commit_lr, commit_pr, flush,
    output req_ready, rsp_pr, rsp_old_pr
  );
endinterface

// File: rtl/rename_ctrl.sv
// Rename controller: owns the PR free list and committed map, and computes the RAT's
// next-state assignments/done flags for rename, writeback, commit and flush recovery.
module rename_ctrl #(
  parameter int unsigned NUM_LRS    = 10,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_PRS    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LRS*ADDR_WIDTH-1:0]   rat_assign,
  input  logic [NUM_LRS-1:0]              rat_done,
  output logic [NUM_LRS*ADDR_WIDTH-1:0]   assign_next,
  output logic [NUM_LRS-1:0]              done_next,
  rename_ctrl_if.slave                    bus,
  output logic [$clog2(NUM_PRS+1)-1:0]    free_count,
  output logic                            busy
);

  localparam int unsigned LW  = $clog2(NUM_LRS);
  localparam int unsigned FCW = $clog2(NUM_PRS + 1);
  localparam int unsigned AW  = ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_RESTORE,
    ST_SWEEP
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_PRS-1:0]      free_q, free_d;
  logic [NUM_LRS*AW-1:0]   cmap_q, cmap_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;

  logic [AW-1:0]           alloc_pr;
  logic                    any_free;
  logic                    sweep_hit;
  logic                    hs;
  logic                    commit_hit;
  logic [AW-1:0]           old_pr;

  // LR i -> PR i, the map loaded at power-up.
  function automatic logic [NUM_LRS*AW-1:0] identity_map();
    logic [NUM_LRS*AW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_LRS); i++) begin
      r[i*AW +: AW] = AW'(i);
    end
    return r;
  endfunction

  // Every PR above the identity-mapped range starts free.
  function automatic logic [NUM_PRS-1:0] reset_free();
    logic [NUM_PRS-1:0] r;
    r = '0;
    for (int p = 0; p < int'(NUM_PRS); p++) begin
      r[p] = (p >= int'(NUM_LRS));
    end
    return r;
  endfunction

  // Lowest-index free PR is the allocation candidate.
  always_comb begin
    alloc_pr = '0;
    any_free = |free_q;
    for (int p = int'(NUM_PRS) - 1; p >= 0; p--) begin
      if (free_q[p]) begin
        alloc_pr = AW'(p);
      end
    end
  end

  // During the sweep, a PR stays allocated iff some LR's committed mapping points at it.
  always_comb begin
    sweep_hit = 1'b0;
    for (int i = 0; i < int'(NUM_LRS); i++) begin
      if (cmap_q[i*AW +: AW] == cnt_q) begin
        sweep_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    free_d         = free_q;
    cmap_d         = cmap_q;
    cnt_d          = cnt_q;
    assign_next    = rat_assign;
    done_next      = rat_done;
    bus.req_ready  = 1'b0;
    bus.rsp_pr     = alloc_pr;
    bus.rsp_old_pr = '0;
    hs             = 1'b0;
    commit_hit     = 1'b0;
    old_pr         = '0;

    unique case (state_q)
      ST_INIT: begin
        assign_next = identity_map();
        done_next   = '1;
        state_d     = ST_RUN;
      end

      ST_RUN: begin
        bus.req_ready = any_free & ~bus.flush;
        hs            = bus.req_valid & bus.req_ready;

        // Writeback sets done first so a same-cycle rename of that LR overrides it.
        for (int i = 0; i < int'(NUM_LRS); i++) begin
          if (bus.wb_valid && (rat_assign[i*AW +: AW] == bus.wb_pr)) begin
            done_next[i] = 1'b1;
          end
          if (LW'(i) == bus.req_lr) begin
            bus.rsp_old_pr = rat_assign[i*AW +: AW];
            if (hs) begin
              assign_next[i*AW +: AW] = alloc_pr;
              done_next[i]            = 1'b0;
            end
          end
          if (bus.commit_valid && (LW'(i) == bus.commit_lr)) begin
            commit_hit            = 1'b1;
            old_pr                = cmap_q[i*AW +: AW];
            cmap_d[i*AW +: AW]    = bus.commit_pr;
          end
        end

        // A PR released by commit becomes allocatable only from next cycle.
        for (int p = 0; p < int'(NUM_PRS); p++) begin
          if (hs && (AW'(p) == alloc_pr)) begin
            free_d[p] = 1'b0;
          end
          if (commit_hit && (old_pr != bus.commit_pr) && (AW'(p) == old_pr)) begin
            free_d[p] = 1'b1;
          end
        end

        if (bus.flush) begin
          state_d = ST_RESTORE;
        end
      end

      ST_RESTORE: begin
        assign_next = cmap_q;
        done_next   = '1;
        free_d      = '0;
        cnt_d       = '0;
        state_d     = ST_SWEEP;
      end

      ST_SWEEP: begin
        for (int p = 0; p < int'(NUM_PRS); p++) begin
          if (AW'(p) == cnt_q) begin
            free_d[p] = ~sweep_hit;
          end
        end
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NUM_PRS - 1)) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Registered free count is the population of the next free bitmap.
  always_comb begin
    fcnt_d = '0;
    for (int p = 0; p < int'(NUM_PRS); p++) begin
      fcnt_d = fcnt_d + FCW'(free_d[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      free_q  <= reset_free();
      cmap_q  <= identity_map();
      cnt_q   <= '0;
      fcnt_q  <= FCW'(NUM_PRS - NUM_LRS);
    end else begin
      state_q <= state_d;
      free_q  <= free_d;
      cmap_q  <= cmap_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign free_count = fcnt_q;
  assign busy       = (state_q != ST_RUN);

endmodule

// File: tb/tb_rename_ctrl.sv
// Bench for rename_ctrl: models the RAT register plus a rename/commit program-order queue,
// and compares the controller's outputs against a set/array-level reference.
module tb_rename_ctrl;
  localparam int unsigned NUM_LRS = 10;
  localparam int unsigned AW      = 5;
  localparam int unsigned NUM_PRS = 32;
  localparam int unsigned LW      = $clog2(NUM_LRS);
  localparam int unsigned FCW     = $clog2(NUM_PRS + 1);
  localparam int PH_INIT = 0, PH_RUN = 1, PH_RESTORE = 2, PH_SWEEP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_LRS*AW-1:0] rat_assign, assign_next;
  logic [NUM_LRS-1:0]    rat_done, done_next;
  logic [FCW-1:0]        free_count;
  logic                  busy;

  rename_ctrl_if #(.NUM_LRS(NUM_LRS), .ADDR_WIDTH(AW)) bus ();

  rename_ctrl #(.NUM_LRS(NUM_LRS), .ADDR_WIDTH(AW), .NUM_PRS(NUM_PRS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rat_assign (rat_assign),
    .rat_done   (rat_done),
    .assign_next(assign_next),
    .done_next  (done_next),
    .bus        (bus),
    .free_count (free_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // The RAT itself: registers whatever next state the controller drives.
  always_ff @(posedge clk) begin
    rat_assign <= assign_next;
    rat_done   <= done_next;
  end

  typedef struct { int lr; int pr; } ent_t;

  int   m_rat [NUM_LRS];
  bit   m_done[NUM_LRS];
  int   m_cmap[NUM_LRS];
  bit   m_free[NUM_PRS];
  int   m_phase;
  int   sweep_left;
  ent_t rob[$];

  bit in_rv, in_wbv, in_cv, in_fl;
  int in_lr, in_wbpr, in_clr, in_cpr;

  logic                  obs_ready, obs_busy;
  logic [AW-1:0]         obs_pr, obs_old;
  logic [NUM_LRS*AW-1:0] obs_assign;
  logic [NUM_LRS-1:0]    obs_done;
  logic [FCW-1:0]        obs_fc;

  logic                  exp_ready, exp_busy, exp_hs, fc_valid;
  logic [AW-1:0]         exp_pr, exp_old;
  logic [NUM_LRS*AW-1:0] exp_assign;
  logic [NUM_LRS-1:0]    exp_done;
  logic [FCW-1:0]        exp_fc;

  int total = 0;
  int bad   = 0;

  task automatic clear_inputs();
    in_rv = 0; in_lr = 0; in_wbv = 0; in_wbpr = 0;
    in_cv = 0; in_clr = 0; in_cpr = 0; in_fl = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LRS; i++) m_cmap[i] = i;
    for (int p = 0; p < NUM_PRS; p++) m_free[p] = (p >= NUM_LRS);
    m_phase = PH_INIT;
    rob.delete();
  endtask

  // Called at a falling edge; holds rst over exactly one rising edge.
  task automatic apply_reset();
    clear_inputs();
    bus.req_valid = 0; bus.wb_valid = 0; bus.commit_valid = 0; bus.flush = 0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, sample outputs, predict, then advance the model.
  task automatic drive_cycle();
    int lowest, cnt, old;
    int n_rat [NUM_LRS];
    bit n_done[NUM_LRS];
    bus.req_valid    = in_rv;
    bus.req_lr       = LW'(in_lr);
    bus.wb_valid     = in_wbv;
    bus.wb_pr        = AW'(in_wbpr);
    bus.commit_valid = in_cv;
    bus.commit_lr    = LW'(in_clr);
    bus.commit_pr    = AW'(in_cpr);
    bus.flush        = in_fl;
    #1;
    obs_ready = bus.req_ready; obs_pr = bus.rsp_pr; obs_old = bus.rsp_old_pr;
    obs_assign = assign_next; obs_done = done_next; obs_busy = busy; obs_fc = free_count;

    lowest = -1;
    cnt    = 0;
    for (int p = 0; p < NUM_PRS; p++) begin
      if (m_free[p] && lowest < 0) lowest = p;
      cnt += int'(m_free[p]);
    end
    exp_fc    = FCW'(cnt);
    fc_valid  = (m_phase == PH_INIT) || (m_phase == PH_RUN);
    exp_busy  = (m_phase != PH_RUN);
    exp_ready = 0; exp_hs = 0; exp_pr = '0; exp_old = '0;
    n_rat  = m_rat;
    n_done = m_done;

    case (m_phase)
      PH_INIT: begin
        for (int i = 0; i < NUM_LRS; i++) begin n_rat[i] = i; n_done[i] = 1; end
        m_phase = PH_RUN;
      end
      PH_RUN: begin
        exp_ready = (lowest >= 0) && !in_fl;
        exp_hs    = in_rv && exp_ready;
        exp_old   = AW'(m_rat[in_lr]);
        if (lowest >= 0) exp_pr = AW'(lowest);
        for (int i = 0; i < NUM_LRS; i++)
          if (in_wbv && m_rat[i] == in_wbpr) n_done[i] = 1;
        if (exp_hs) begin
          n_rat[in_lr] = lowest; n_done[in_lr] = 0; m_free[lowest] = 0;
          rob.push_back('{in_lr, lowest});
        end
        if (in_cv) begin
          old = m_cmap[in_clr];
          m_cmap[in_clr] = in_cpr;
          if (old != in_cpr) m_free[old] = 1;
        end
        if (in_fl) begin m_phase = PH_RESTORE; rob.delete(); end
      end
      PH_RESTORE: begin
        for (int i = 0; i < NUM_LRS; i++) begin n_rat[i] = m_cmap[i]; n_done[i] = 1; end
        for (int p = 0; p < NUM_PRS; p++) m_free[p] = 0;
        m_phase = PH_SWEEP; sweep_left = NUM_PRS;
      end
      default: begin
        sweep_left--;
        if (sweep_left == 0) begin
          for (int p = 0; p < NUM_PRS; p++) m_free[p] = 1;
          for (int i = 0; i < NUM_LRS; i++) m_free[m_cmap[i]] = 0;
          m_phase = PH_RUN;
        end
      end
    endcase

    for (int i = 0; i < NUM_LRS; i++) begin
      exp_assign[i*AW +: AW] = AW'(n_rat[i]);
      exp_done[i]            = n_done[i];
    end
    @(posedge clk);
    m_rat  = n_rat;
    m_done = n_done;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [NUM_LRS*AW-1:0] ident;
    for (int i = 0; i < NUM_LRS; i++) ident[i*AW +: AW] = AW'(i);
    apply_reset();
    drive_cycle();
    total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL init_busy: got %b want 1", obs_busy); end
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL init_ready: got %b want 0", obs_ready); end
    total++; if (obs_assign !== ident) begin bad++; $display("FAIL init_assign: got %h want %h", obs_assign, ident); end
    total++; if (obs_done !== 10'h3FF) begin bad++; $display("FAIL init_done: got %h want 3ff", obs_done); end
    total++; if (obs_fc !== FCW'(22)) begin bad++; $display("FAIL init_free_count: got %0d want 22", obs_fc); end
    drive_cycle();
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL run_ready: got %b want 1", obs_ready); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL run_busy: got %b want 0", obs_busy); end
    total++; if (obs_fc !== FCW'(22)) begin bad++; $display("FAIL run_free_count: got %0d want 22", obs_fc); end
  endtask

  task automatic test_rename();
    clear_inputs();
    in_rv = 1; in_lr = 3;
    drive_cycle();
    total++; if (obs_pr !== 5'd10 || obs_pr !== exp_pr) begin bad++; $display("FAIL rename1_pr: got %0d want 10", obs_pr); end
    total++; if (obs_old !== 5'd3) begin bad++; $display("FAIL rename1_old: got %0d want 3", obs_old); end
    total++; if (obs_done[3] !== 1'b0) begin bad++; $display("FAIL rename1_done3: got %b want 0", obs_done[3]); end
    total++; if (obs_assign !== exp_assign) begin bad++; $display("FAIL rename1_assign: got %h want %h", obs_assign, exp_assign); end
    drive_cycle();
    total++; if (obs_pr !== 5'd11) begin bad++; $display("FAIL rename2_pr: got %0d want 11", obs_pr); end
    total++; if (obs_old !== 5'd10) begin bad++; $display("FAIL rename2_old: got %0d want 10", obs_old); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive_cycle();
    for (int k = 0; k < 22; k++) begin
      in_rv = 1;
      in_lr = (k == 0) ? 3 : ((k % 3 == 0) ? 5 : int'($urandom_range(0, NUM_LRS - 1)));
      if (in_lr == 3 && k != 0) in_lr = 4;
      drive_cycle();
      total++; if (obs_ready !== 1'b1 || obs_pr !== exp_pr) begin
        bad++; $display("FAIL b2b_grant%0d: ready=%b pr=%0d want ready=1 pr=%0d", k, obs_ready, obs_pr, exp_pr);
      end
    end
    in_rv = 1; in_lr = 7;
    drive_cycle();
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL empty_ready: got %b want 0", obs_ready); end
    total++; if (obs_fc !== FCW'(0)) begin bad++; $display("FAIL empty_free_count: got %0d want 0", obs_fc); end
    clear_inputs();
    in_cv = 1; in_clr = 3; in_cpr = 10;
    drive_cycle();
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL commit_cycle_ready: got %b want 0", obs_ready); end
    clear_inputs();
    in_rv = 1; in_lr = 0;
    drive_cycle();
    total++; if (obs_fc !== FCW'(1)) begin bad++; $display("FAIL after_commit_free_count: got %0d want 1", obs_fc); end
    total++; if (obs_ready !== 1'b1 || obs_pr !== 5'd3) begin
      bad++; $display("FAIL freed_pr_grant: ready=%b pr=%0d want ready=1 pr=3", obs_ready, obs_pr);
    end
    clear_inputs();
  endtask

  task automatic test_wb();
    apply_reset();
    drive_cycle();
    in_rv = 1; in_lr = 3;
    drive_cycle();
    drive_cycle();
    in_wbv = 1; in_wbpr = 11;
    drive_cycle();
    total++; if (obs_done[3] !== 1'b0) begin bad++; $display("FAIL wb_vs_rename_done3: got %b want 0", obs_done[3]); end
    total++; if (obs_pr !== 5'd12) begin bad++; $display("FAIL wb_vs_rename_pr: got %0d want 12", obs_pr); end
    clear_inputs();
    in_rv = 1; in_lr = 4;
    drive_cycle();
    clear_inputs();
    in_wbv = 1; in_wbpr = 13;
    drive_cycle();
    total++; if (obs_done[4] !== 1'b1) begin bad++; $display("FAIL wb_alone_done4: got %b want 1", obs_done[4]); end
    total++; if (obs_done !== exp_done) begin bad++; $display("FAIL wb_alone_done: got %h want %h", obs_done, exp_done); end
    in_wbpr = 11;
    drive_cycle();
    total++; if (obs_done[3] !== 1'b0) begin bad++; $display("FAIL wb_stale_done3: got %b want 0", obs_done[3]); end
    clear_inputs();
  endtask

  task automatic test_flush();
    int n;
    in_cv = 1; in_clr = 3; in_cpr = 10;
    drive_cycle();
    clear_inputs();
    in_rv = 1; in_lr = 2; in_fl = 1; in_cv = 1; in_clr = 3; in_cpr = 11;
    drive_cycle();
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", obs_ready); end
    clear_inputs();
    drive_cycle();
    total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL restore_busy: got %b want 1", obs_busy); end
    total++; if (obs_assign !== exp_assign || obs_assign[3*AW +: AW] !== 5'd11) begin
      bad++; $display("FAIL restore_assign: got %h want %h", obs_assign, exp_assign);
    end
    total++; if (obs_done !== 10'h3FF) begin bad++; $display("FAIL restore_done: got %h want 3ff", obs_done); end
    n = 1;
    while (n < 100) begin
      drive_cycle();
      if (!obs_busy) break;
      n++;
    end
    total++; if (n !== 33) begin bad++; $display("FAIL flush_busy_cycles: got %0d want 33", n); end
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL post_flush_ready: got %b want 1", obs_ready); end
    total++; if (obs_fc !== FCW'(22)) begin bad++; $display("FAIL post_flush_free_count: got %0d want 22", obs_fc); end
    in_rv = 1; in_lr = 6;
    drive_cycle();
    total++; if (obs_pr !== 5'd3 || obs_pr !== exp_pr) begin bad++; $display("FAIL post_flush_grant: got %0d want 3", obs_pr); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    logic [NUM_LRS*AW-1:0] ident;
    for (int i = 0; i < NUM_LRS; i++) ident[i*AW +: AW] = AW'(i);
    in_rv = 1; in_lr = 1;
    drive_cycle();
    clear_inputs();
    in_fl = 1;
    drive_cycle();
    clear_inputs();
    for (int k = 0; k < 11; k++) drive_cycle();
    apply_reset();
    drive_cycle();
    total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL midsweep_rst_busy: got %b want 1", obs_busy); end
    total++; if (obs_assign !== ident) begin bad++; $display("FAIL midsweep_rst_assign: got %h want %h", obs_assign, ident); end
    total++; if (obs_fc !== FCW'(22)) begin bad++; $display("FAIL midsweep_rst_free_count: got %0d want 22", obs_fc); end
    drive_cycle();
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL midsweep_rst_run_ready: got %b want 1", obs_ready); end
  endtask

  task automatic test_random();
    ent_t e;
    apply_reset();
    drive_cycle();
    for (int k = 0; k < 800; k++) begin
      clear_inputs();
      in_rv  = ($urandom_range(0, 99) < 60);
      in_lr  = int'($urandom_range(0, NUM_LRS - 1));
      in_wbv = ($urandom_range(0, 99) < 40);
      in_wbpr = int'($urandom_range(0, NUM_PRS - 1));
      if (m_phase == PH_RUN && rob.size() > 0 && $urandom_range(0, 99) < 35) begin
        e = rob.pop_front();
        in_cv = 1; in_clr = e.lr; in_cpr = e.pr;
      end
      in_fl = ($urandom_range(0, 99) < 2);
      drive_cycle();
      total++; if (obs_busy !== exp_busy || obs_ready !== exp_ready) begin
        bad++; $display("FAIL rnd%0d_ctrl: busy=%b ready=%b want busy=%b ready=%b", k, obs_busy, obs_ready, exp_busy, exp_ready);
      end
      total++; if (obs_assign !== exp_assign || obs_done !== exp_done) begin
        bad++; $display("FAIL rnd%0d_rat: assign=%h done=%h want assign=%h done=%h", k, obs_assign, obs_done, exp_assign, exp_done);
      end
      if (fc_valid) begin
        total++; if (obs_fc !== exp_fc) begin bad++; $display("FAIL rnd%0d_free_count: got %0d want %0d", k, obs_fc, exp_fc); end
      end
      if (exp_hs) begin
        total++; if (obs_pr !== exp_pr || obs_old !== exp_old) begin
          bad++; $display("FAIL rnd%0d_rsp: pr=%0d old=%0d want pr=%0d old=%0d", k, obs_pr, obs_old, exp_pr, exp_old);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_rename();
    test_back_to_back();
    test_wb();
    test_flush();
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
